// File: rtl/biriscv_defs.sv
// Shared definitions for the instruction-fetch responder: privilege levels,
// responder state encoding and line-address helpers.
package biriscv_defs;

  localparam logic [1:0] PRIV_USER    = 2'd0;
  localparam logic [1:0] PRIV_SUPER   = 2'd1;
  localparam logic [1:0] PRIV_MACHINE = 2'd3;

  localparam int TAG_W  = 29;
  localparam int LINE_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } fetch_state_t;

  function automatic logic [TAG_W-1:0] line_tag(input logic [31:0] pc);
    return pc[31:3];
  endfunction

  // The subtraction wraps, so one unsigned compare covers both window edges.
  function automatic logic in_window(input logic [31:0] pc,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return ((pc - base) < size);
  endfunction

endpackage

// File: rtl/biriscv_ifetch_linebuf.sv
// One-line fetch buffer: a single tag/data/valid entry with hit compare,
// fill and clear. Clear takes priority over fill.
module biriscv_ifetch_linebuf
  import biriscv_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [LINE_W-1:0] data
);

  logic              valid_r;
  logic [TAG_W-1:0]  tag_r;
  logic [LINE_W-1:0] data_r;

  // Entry storage: clear wins over fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
      data_r  <= '0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (fill) begin
      valid_r <= 1'b1;
      tag_r   <= fill_tag;
      data_r  <= fill_data;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign hit  = valid_r && (tag_r == lookup_tag);
  assign data = data_r;

endmodule

// File: rtl/biriscv_ifetch_responder.sv
// Responder end of the core instruction-fetch port: range and privilege
// checks, a one-line buffer for repeat hits, and a single-outstanding miss path.
module biriscv_ifetch_responder
  import biriscv_defs::*;
#(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0001_0000,
  parameter logic [31:0] USER_TOP   = 32'h8000_8000,
  parameter bit          BUF_ENABLE = 1'b1
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_rd_i,
  input  logic [31:0] icache_pc_i,
  input  logic [1:0]  icache_priv_i,
  input  logic        icache_flush_i,
  input  logic        icache_invalidate_i,
  output logic        icache_accept_o,
  output logic        icache_valid_o,
  output logic        icache_error_o,
  output logic        icache_page_fault_o,
  output logic [63:0] icache_inst_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic        mem_error_i,
  input  logic [63:0] mem_data_i
);

  fetch_state_t state_r;
  logic         flush_pend_r;
  logic         valid_r;
  logic         error_r;
  logic         page_fault_r;
  logic [63:0]  inst_r;
  logic         mem_rd_r;
  logic [31:0]  mem_addr_r;

  logic         flush_req_s;
  logic         accept_s;
  logic         take_s;
  logic         in_win_s;
  logic         user_fault_s;
  logic         mem_resp_s;
  logic         flush_now_s;
  logic         lb_clear_s;
  logic         lb_fill_s;
  logic         lb_hit_s;
  logic         hit_s;
  logic [63:0]  lb_data_s;
  logic         pc_lsb_unused_s;

  assign pc_lsb_unused_s = ^icache_pc_i[2:0];

  biriscv_ifetch_linebuf u_linebuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (lb_clear_s),
    .fill       (lb_fill_s),
    .fill_tag   (line_tag(mem_addr_r)),
    .fill_data  (mem_data_i),
    .lookup_tag (line_tag(icache_pc_i)),
    .hit        (lb_hit_s),
    .data       (lb_data_s)
  );

  // Accept, request checks and buffer maintenance for the current cycle
  always_comb begin
    flush_req_s  = icache_flush_i || icache_invalidate_i;
    accept_s     = rst_n && (state_r == ST_IDLE) && !flush_pend_r && !flush_req_s;
    take_s       = icache_rd_i && accept_s;
    in_win_s     = in_window(icache_pc_i, MEM_BASE, MEM_SIZE);
    user_fault_s = (icache_priv_i == PRIV_USER) && (icache_pc_i >= USER_TOP);
    hit_s        = BUF_ENABLE && lb_hit_s;
    flush_now_s  = flush_pend_r || flush_req_s;
    mem_resp_s   = 1'b0;
    lb_clear_s   = 1'b0;
    lb_fill_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_FLUSH: begin
        lb_clear_s = flush_req_s;
      end
      ST_MEM_REQ: begin
        mem_resp_s = mem_accept_i && mem_valid_i;
      end
      ST_MEM_WAIT: begin
        mem_resp_s = mem_valid_i;
      end
      default: begin
        mem_resp_s = 1'b0;
      end
    endcase
    if (mem_resp_s) begin
      lb_clear_s = flush_now_s;
      lb_fill_s  = BUF_ENABLE && !mem_error_i && !flush_now_s;
    end else begin
      lb_fill_s  = 1'b0;
    end
  end

  // Responder FSM with registered response and backing-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      flush_pend_r <= 1'b0;
      valid_r      <= 1'b0;
      error_r      <= 1'b0;
      page_fault_r <= 1'b0;
      inst_r       <= 64'h0;
      mem_rd_r     <= 1'b0;
      mem_addr_r   <= 32'h0;
    end else begin
      valid_r      <= 1'b0;
      error_r      <= 1'b0;
      page_fault_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (flush_req_s) begin
            state_r <= ST_FLUSH;
          end else if (take_s) begin
            if (!in_win_s) begin
              valid_r <= 1'b1;
              error_r <= 1'b1;
              inst_r  <= 64'h0;
            end else if (user_fault_s) begin
              valid_r      <= 1'b1;
              page_fault_r <= 1'b1;
              inst_r       <= 64'h0;
            end else if (hit_s) begin
              valid_r <= 1'b1;
              inst_r  <= lb_data_s;
            end else begin
              state_r    <= ST_MEM_REQ;
              mem_rd_r   <= 1'b1;
              mem_addr_r <= {icache_pc_i[31:3], 3'b000};
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MEM_REQ, ST_MEM_WAIT: begin
          if (flush_req_s) begin
            flush_pend_r <= 1'b1;
          end else begin
            flush_pend_r <= flush_pend_r;
          end
          if ((state_r == ST_MEM_REQ) && mem_accept_i) begin
            mem_rd_r <= 1'b0;
            state_r  <= ST_MEM_WAIT;
          end else begin
            mem_rd_r <= mem_rd_r;
          end
          // A pending flush is honoured straight after the response
          if (mem_resp_s) begin
            valid_r      <= 1'b1;
            error_r      <= mem_error_i;
            inst_r       <= mem_error_i ? 64'h0 : mem_data_i;
            flush_pend_r <= 1'b0;
            state_r      <= flush_now_s ? ST_FLUSH : ST_IDLE;
          end else begin
            inst_r <= inst_r;
          end
        end
        ST_FLUSH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign icache_accept_o     = accept_s;
  assign icache_valid_o      = valid_r;
  assign icache_error_o      = error_r;
  assign icache_page_fault_o = page_fault_r;
  assign icache_inst_o       = inst_r;
  assign mem_rd_o            = mem_rd_r;
  assign mem_addr_o          = mem_addr_r;

endmodule

// File: tb/tb_biriscv_ifetch_responder.sv
// Directed bench for biriscv_ifetch_responder: a vector table of single fetches
// against a small latency-programmable memory, plus flush and reset sequences.
module tb_biriscv_ifetch_responder;
  import biriscv_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_rd_i = 1'b0;
  logic [31:0] icache_pc_i = 32'h0;
  logic [1:0]  icache_priv_i = 2'd0;
  logic        icache_flush_i = 1'b0;
  logic        icache_invalidate_i = 1'b0;
  logic        icache_accept_o, icache_valid_o, icache_error_o, icache_page_fault_o;
  logic [63:0] icache_inst_o;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic        mem_accept_i = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic        mem_error_i = 1'b0;
  logic [63:0] mem_data_i = 64'h0;

  biriscv_ifetch_responder dut (
    .clk(clk), .rst_n(rst_n),
    .icache_rd_i(icache_rd_i), .icache_pc_i(icache_pc_i), .icache_priv_i(icache_priv_i),
    .icache_flush_i(icache_flush_i), .icache_invalidate_i(icache_invalidate_i),
    .icache_accept_o(icache_accept_o), .icache_valid_o(icache_valid_o),
    .icache_error_o(icache_error_o), .icache_page_fault_o(icache_page_fault_o),
    .icache_inst_o(icache_inst_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
    .mem_accept_i(mem_accept_i), .mem_valid_i(mem_valid_i),
    .mem_error_i(mem_error_i), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model settings and bookkeeping
  int          acc_delay_m = 0;
  int          lat_m = 0;
  logic        err_m = 1'b0;
  logic [63:0] data_m = 64'h0;
  bit          inject_late = 1'b0;
  int          wait_cnt = 0;
  int          cnt = 0;
  int          mv_cyc = 0;

  int          cyc = 0;
  int          memreq_cnt = 0;
  logic [31:0] last_mem_addr = 32'h0;
  int          stab_err = 0;
  int          ov_err = 0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  // Backing memory: accept after acc_delay_m cycles, data lat_m cycles later
  always begin
    @(posedge clk);
    #2;
    mem_accept_i = 1'b0;
    mem_valid_i  = 1'b0;
    mem_error_i  = 1'b0;
    mem_data_i   = 64'h0;
    if (!rst_n) begin
      wait_cnt = 0;
      cnt      = 0;
    end else if (inject_late) begin
      mem_valid_i = 1'b1;
      mem_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (mem_rd_o) begin
      if (wait_cnt >= acc_delay_m) begin
        mem_accept_i = 1'b1;
        wait_cnt     = 0;
        if (lat_m == 0) begin
          mem_valid_i = 1'b1;
          mem_error_i = err_m;
          mem_data_i  = data_m;
          mv_cyc      = cyc;
        end else begin
          cnt = lat_m;
        end
      end else begin
        wait_cnt++;
      end
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem_valid_i = 1'b1;
        mem_error_i = err_m;
        mem_data_i  = data_m;
        mv_cyc      = cyc;
      end
    end
  end

  // Backing-port monitor: accepted requests, address stability, no overlap
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_o && mem_accept_i) begin
      memreq_cnt    <= memreq_cnt + 1;
      last_mem_addr <= mem_addr_o;
    end
    if (rst_n && mem_rd_o && prev_rd && (mem_addr_o != prev_addr)) stab_err <= stab_err + 1;
    if (mem_rd_o && icache_accept_o) ov_err <= ov_err + 1;
    prev_rd   <= mem_rd_o;
    prev_addr <= mem_addr_o;
  end

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  priv;
    int          acc_d;
    int          lat;
    logic        merr;
    logic [63:0] mdata;
    logic        exp_mem;
    logic        exp_err;
    logic        exp_pf;
    logic [63:0] exp_inst;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v, input string tag);
    int n = 0;
    int req_cyc = 0;
    int r_cyc = 0;
    int m0;
    int extra = 0;
    int busy = 0;
    bit got = 1'b0;
    logic e = 1'b0, p = 1'b0;
    logic [63:0] d = 64'h0;
    acc_delay_m = v.acc_d;
    lat_m       = v.lat;
    err_m       = v.merr;
    data_m      = v.mdata;
    while (!icache_accept_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 64'(icache_accept_o), 64'd1);
    m0 = memreq_cnt;
    icache_rd_i   = 1'b1;
    icache_pc_i   = v.pc;
    icache_priv_i = v.priv;
    step();
    req_cyc     = cyc;
    icache_rd_i = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (icache_valid_o) begin
        got   = 1'b1;
        r_cyc = cyc;
        e     = icache_error_o;
        p     = icache_page_fault_o;
        d     = icache_inst_o;
      end else if (icache_accept_o) begin
        busy++;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (icache_valid_o) extra++;
    end
    chk({tag, "_valid"}, 64'(got), 64'd1);
    chk({tag, "_extra_valid"}, 64'(extra), 64'd0);
    chk({tag, "_accept_busy"}, 64'(busy), 64'd0);
    chk({tag, "_error"}, 64'(e), 64'(v.exp_err));
    chk({tag, "_page_fault"}, 64'(p), 64'(v.exp_pf));
    chk({tag, "_inst"}, d, v.exp_inst);
    chk({tag, "_mem_reqs"}, 64'(memreq_cnt - m0), 64'(v.exp_mem));
    chk({tag, "_latency"}, 64'(r_cyc), v.exp_mem ? 64'(mv_cyc + 1) : 64'(req_cyc));
    if (v.exp_mem) chk({tag, "_mem_addr"}, 64'(last_mem_addr), 64'({v.pc[31:3], 3'b000}));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_accept"}, 64'(icache_accept_o), 64'd0);
    chk({tag, "_valid"}, 64'(icache_valid_o), 64'd0);
    chk({tag, "_err_pf"}, 64'({icache_error_o, icache_page_fault_o}), 64'd0);
    chk({tag, "_inst"}, icache_inst_o, 64'd0);
    chk({tag, "_mem_rd"}, 64'(mem_rd_o), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
  endtask

  initial begin
    int n;
    bit got;
    int late;
    vec_t v;

    //          pc             priv          acc lat merr  mdata                   mem   err   pf    inst
    vecs[0]  = '{32'h8000_0004, PRIV_MACHINE, 0, 3, 1'b0, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0, 64'h1111_2222_3333_4444};
    vecs[1]  = '{32'h8000_0000, PRIV_MACHINE, 0, 0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b0, 64'h1111_2222_3333_4444};
    vecs[2]  = '{32'h7FFF_FFF8, PRIV_MACHINE, 0, 0, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b0, 64'h0};
    vecs[3]  = '{32'h8001_0000, PRIV_MACHINE, 0, 0, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b0, 64'h0};
    vecs[4]  = '{32'h8000_FFF8, PRIV_MACHINE, 0, 1, 1'b0, 64'hA5A5_5A5A_0123_4567, 1'b1, 1'b0, 1'b0, 64'hA5A5_5A5A_0123_4567};
    vecs[5]  = '{32'h8000_8000, PRIV_USER,    0, 0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b1, 64'h0};
    vecs[6]  = '{32'h8000_7FF8, PRIV_USER,    0, 0, 1'b0, 64'h0000_0000_CAFE_F00D, 1'b1, 1'b0, 1'b0, 64'h0000_0000_CAFE_F00D};
    vecs[7]  = '{32'h8000_8000, PRIV_SUPER,   5, 2, 1'b0, 64'h7777_8888_9999_AAAA, 1'b1, 1'b0, 1'b0, 64'h7777_8888_9999_AAAA};
    vecs[8]  = '{32'h8000_8000, PRIV_USER,    0, 0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b1, 64'h0};
    vecs[9]  = '{32'h8000_8004, PRIV_MACHINE, 0, 0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b0, 64'h7777_8888_9999_AAAA};
    vecs[10] = '{32'h8000_0100, PRIV_MACHINE, 1, 2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'h0};
    vecs[11] = '{32'h8000_0100, PRIV_MACHINE, 0, 2, 1'b0, 64'h0102_0304_0506_0708, 1'b1, 1'b0, 1'b0, 64'h0102_0304_0506_0708};
    vecs[12] = '{32'h8000_0104, PRIV_USER,    0, 0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b0, 64'h0102_0304_0506_0708};
    vecs[13] = '{32'h8000_8004, PRIV_MACHINE, 0, 1, 1'b0, 64'h1357_9BDF_2468_ACE0, 1'b1, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0};

    #1;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_accept", 64'(icache_accept_o), 64'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Flush while the miss is outstanding
    acc_delay_m = 0; lat_m = 4; err_m = 1'b0; data_m = 64'h0F0F_F0F0_1234_5678;
    icache_rd_i = 1'b1; icache_pc_i = 32'h8000_0200; icache_priv_i = PRIV_MACHINE;
    step();
    icache_rd_i = 1'b0;
    step();
    step();
    icache_flush_i = 1'b1;
    step();
    icache_flush_i = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (icache_valid_o) got = 1'b1;
    end
    chk("fl_valid", 64'(got), 64'd1);
    chk("fl_inst", icache_inst_o, 64'h0F0F_F0F0_1234_5678);
    chk("fl_flush_accept", 64'(icache_accept_o), 64'd0);
    @(negedge clk);
    chk("fl_after_accept", 64'(icache_accept_o), 64'd1);
    v = '{32'h8000_0200, PRIV_MACHINE, 0, 2, 1'b0, 64'h2222_0000_2222_0000, 1'b1, 1'b0, 1'b0, 64'h2222_0000_2222_0000};
    run_vec(v, "fl_refetch");

    // Invalidate in IDLE with a simultaneous request: not accepted, buffer cleared
    step();
    icache_rd_i = 1'b1; icache_pc_i = 32'h8000_0200; icache_invalidate_i = 1'b1;
    #1;
    chk("inv_accept_forced", 64'(icache_accept_o), 64'd0);
    step();
    icache_rd_i = 1'b0; icache_invalidate_i = 1'b0;
    @(negedge clk);
    chk("inv_no_valid", 64'(icache_valid_o), 64'd0);
    chk("inv_flush_accept", 64'(icache_accept_o), 64'd0);
    v = '{32'h8000_0200, PRIV_MACHINE, 0, 1, 1'b0, 64'h3333_4444_5555_6666, 1'b1, 1'b0, 1'b0, 64'h3333_4444_5555_6666};
    run_vec(v, "inv_refetch");

    // Reset in the middle of a miss, then a stray late response
    acc_delay_m = 0; lat_m = 10; err_m = 1'b0; data_m = 64'h4444_4444_4444_4444;
    step();
    icache_rd_i = 1'b1; icache_pc_i = 32'h8000_0300; icache_priv_i = PRIV_MACHINE;
    step();
    icache_rd_i = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step();
    step();
    rst_n = 1'b1;
    step();
    inject_late = 1'b1;
    step();
    inject_late = 1'b0;
    late = 0;
    repeat (3) begin
      @(negedge clk);
      if (icache_valid_o) late++;
    end
    chk("rst_late_valid", 64'(late), 64'd0);
    chk("rst_late_accept", 64'(icache_accept_o), 64'd1);

    chk("mem_addr_stable", 64'(stab_err), 64'd0);
    chk("no_accept_while_mem_rd", 64'(ov_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
